// File: rtl/jtag_types_pkg.sv
// Shared JTAG type definitions: opcode width and the instruction encodings
// recognised by the TAP instruction path.
package jtag_types_pkg;

   localparam int unsigned OPCODE_W = 4;

   typedef logic [OPCODE_W-1:0] opcode_t;

   localparam opcode_t EXTEST        = 4'h0;
   localparam opcode_t SAMPLE        = 4'h1;
   localparam opcode_t PRELOAD       = 4'h2;
   localparam opcode_t IDCODE        = 4'h3;
   localparam opcode_t CLAMP_HOLD    = 4'h4;
   localparam opcode_t CLAMP_RELEASE = 4'h5;
   localparam opcode_t AHB           = 4'h8;
   localparam opcode_t BYPASS        = 4'hF;

endpackage

// File: rtl/instruction_register.sv
// JTAG instruction register: capture/shift chain plus a legalised update
// register driving instruction_decoder. Optional odd-parity protection of the
// shifted instruction is enabled by defining IR_PARITY_EN.
module instruction_register
   import jtag_types_pkg::*;
#(
   parameter int unsigned IR_WIDTH = 4,
   parameter int unsigned STATUS_W = IR_WIDTH - 2
) (
   input  logic                TCK,
   input  logic                TRST,
   input  logic                tlr_reset,
   input  logic                capture_ir,
   input  logic                shift_ir,
   input  logic                update_ir,
   input  logic                tdi,
   input  logic [STATUS_W-1:0] status,
   output logic                ir_tdo,
   output logic [IR_WIDTH-1:0] parallel_out,
   output logic                update_pulse,
   output logic                parity_err
);

`ifdef IR_PARITY_EN
   localparam int unsigned CHAIN_W = IR_WIDTH + 1;
`else
   localparam int unsigned CHAIN_W = IR_WIDTH;
`endif

   localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(IDCODE);
   localparam logic [IR_WIDTH-1:0] OP_BYPASS = IR_WIDTH'(BYPASS);

   logic [CHAIN_W-1:0]  shift_reg;
   logic [CHAIN_W-1:0]  capture_val;
   logic [IR_WIDTH-1:0] upd_reg;
   logic [IR_WIDTH-1:0] opc;
   logic [IR_WIDTH-1:0] upd_next;
   logic                opc_legal;
   logic                parity_ok;

   assign opc = shift_reg[IR_WIDTH-1:0];

   // Legal-set check against package encodings and the value an update commits
   always_comb begin
      opc_legal = (opc == IR_WIDTH'(BYPASS))        ||
                  (opc == IR_WIDTH'(SAMPLE))        ||
                  (opc == IR_WIDTH'(PRELOAD))       ||
                  (opc == IR_WIDTH'(EXTEST))        ||
                  (opc == IR_WIDTH'(IDCODE))        ||
                  (opc == IR_WIDTH'(AHB))           ||
                  (opc == IR_WIDTH'(CLAMP_HOLD))    ||
                  (opc == IR_WIDTH'(CLAMP_RELEASE));
`ifdef IR_PARITY_EN
      parity_ok   = ^shift_reg;
      capture_val = CHAIN_W'({1'b0, status, 2'b01});
`else
      parity_ok   = 1'b1;
      capture_val = CHAIN_W'({status, 2'b01});
`endif
      upd_next = (parity_ok && opc_legal) ? opc : OP_BYPASS;
   end

   // Chain, update register and strobes, in priority TRST > tlr > update > capture > shift
   always_ff @(posedge TCK) begin
      if (TRST) begin
         shift_reg    <= '0;
         upd_reg      <= OP_IDCODE;
         update_pulse <= 1'b0;
`ifdef IR_PARITY_EN
         parity_err   <= 1'b0;
`endif
      end else if (tlr_reset) begin
         upd_reg      <= OP_IDCODE;
         update_pulse <= 1'b0;
`ifdef IR_PARITY_EN
         parity_err   <= 1'b0;
`endif
      end else if (update_ir) begin
         upd_reg      <= upd_next;
         update_pulse <= 1'b1;
`ifdef IR_PARITY_EN
         parity_err   <= ~parity_ok;
`endif
      end else begin
         update_pulse <= 1'b0;
         if (capture_ir) begin
            shift_reg <= capture_val;
         end else if (shift_ir) begin
            shift_reg <= {tdi, shift_reg[CHAIN_W-1:1]};
         end
      end
   end

`ifndef IR_PARITY_EN
   assign parity_err = 1'b0;
`endif

   assign ir_tdo       = shift_reg[0];
   assign parallel_out = upd_reg;

endmodule

// File: tb/tb_instruction_register.sv
// Directed self-checking bench for instruction_register with a scoreboard
// queue of expected values. Covers the IR_PARITY_EN build when defined.
module tb_instruction_register;
   import jtag_types_pkg::*;

   localparam int unsigned W = 4;
`ifdef IR_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif

   logic         TCK = 1'b0;
   logic         TRST, tlr_reset, capture_ir, shift_ir, update_ir, tdi;
   logic [W-3:0] status;
   logic         ir_tdo;
   logic [W-1:0] parallel_out;
   logic         update_pulse;
   logic         parity_err;

   instruction_register #(.IR_WIDTH(W)) dut (
      .TCK          (TCK),
      .TRST         (TRST),
      .tlr_reset    (tlr_reset),
      .capture_ir   (capture_ir),
      .shift_ir     (shift_ir),
      .update_ir    (update_ir),
      .tdi          (tdi),
      .status       (status),
      .ir_tdo       (ir_tdo),
      .parallel_out (parallel_out),
      .update_pulse (update_pulse),
      .parity_err   (parity_err)
   );

   always #5 TCK = ~TCK;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t         sbq[$];
   int           errors = 0;
   int           checks = 0;
   logic [W-1:0] cur_po;
   logic [W-1:0] legal_tbl [8];

   function automatic logic [W-1:0] legalise(input logic [W-1:0] v);
      for (int i = 0; i < 8; i++)
         if (legal_tbl[i] == v) return v;
      return BYPASS;
   endfunction

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sbq.push_back(e);
   endtask

   task automatic pop(input logic [31:0] obs);
      exp_t e;
      checks++;
      assert (sbq.size() != 0) else begin
         errors++;
         $error("FAIL sb_empty observed=%0h expected=none", obs);
      end
      if (sbq.size() != 0) begin
         e = sbq.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic step();
      @(posedge TCK);
      #1;
   endtask

   // Shift an opcode LSB first (plus parity bit when enabled); parallel_out must not move.
   task automatic shift_word(input logic [W-1:0] val, input bit flip);
      shift_ir = 1'b1;
      for (int i = 0; i < int'(W); i++) begin
         tdi = val[i];
         push("po_stable_shift", 32'(cur_po));
         step();
         pop(32'(parallel_out));
      end
      if (PAR) begin
         tdi = (~^val) ^ flip;
         step();
      end
      shift_ir = 1'b0;
      tdi      = 1'b0;
   endtask

   task automatic commit(input logic [W-1:0] val, input bit flip);
      logic [W-1:0] exp_po;
      shift_word(val, flip);
      exp_po = (PAR && flip) ? BYPASS : legalise(val);
      update_ir = 1'b1;
      push("commit_po", 32'(exp_po));
      push("pulse_hi", 32'd1);
      push("perr_commit", 32'(PAR && flip));
      step();
      pop(32'(parallel_out));
      pop(32'(update_pulse));
      pop(32'(parity_err));
      update_ir = 1'b0;
      cur_po    = exp_po;
      push("pulse_lo", 32'd0);
      push("po_hold", 32'(exp_po));
      step();
      pop(32'(update_pulse));
      pop(32'(parallel_out));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      legal_tbl = '{BYPASS, SAMPLE, PRELOAD, EXTEST, IDCODE, AHB, CLAMP_HOLD, CLAMP_RELEASE};
      TRST = 1'b1; tlr_reset = 1'b0; capture_ir = 1'b0; shift_ir = 1'b0;
      update_ir = 1'b0; tdi = 1'b0; status = '0;

      // Reset state
      push("rst_po", 32'(IDCODE));
      push("rst_tdo", 32'd0);
      push("rst_pulse", 32'd0);
      push("rst_perr", 32'd0);
      step();
      pop(32'(parallel_out));
      pop(32'(ir_tdo));
      pop(32'(update_pulse));
      pop(32'(parity_err));
      TRST   = 1'b0;
      cur_po = IDCODE;

      // Capture pattern then shift out with tdi=0: 1,0,0,1 then 0
      status     = 2'b10;
      capture_ir = 1'b1;
      push("cap_tdo0", 32'd1);
      step();
      pop(32'(ir_tdo));
      capture_ir = 1'b0;
      shift_ir   = 1'b1;
      tdi        = 1'b0;
      push("cap_tdo1", 32'd0); step(); pop(32'(ir_tdo));
      push("cap_tdo2", 32'd0); step(); pop(32'(ir_tdo));
      push("cap_tdo3", 32'd1); step(); pop(32'(ir_tdo));
      push("cap_tdo_empty", 32'd0);
      push("cap_po_stable", 32'(IDCODE));
      step();
      pop(32'(ir_tdo));
      pop(32'(parallel_out));
      shift_ir = 1'b0;

      // Legal and illegal commits
      commit(EXTEST, 1'b0);
      commit(4'h6, 1'b0);
      commit(SAMPLE, 1'b0);
      commit(4'hA, 1'b0);
      commit(CLAMP_RELEASE, 1'b0);

      // update_ir held two cycles: two pulses, same value
      shift_word(PRELOAD, 1'b0);
      update_ir = 1'b1;
      push("hold_pulse1", 32'd1); push("hold_po1", 32'(PRELOAD));
      step(); pop(32'(update_pulse)); pop(32'(parallel_out));
      push("hold_pulse2", 32'd1); push("hold_po2", 32'(PRELOAD));
      step(); pop(32'(update_pulse)); pop(32'(parallel_out));
      update_ir = 1'b0;
      push("hold_pulse_end", 32'd0);
      step(); pop(32'(update_pulse));
      cur_po = PRELOAD;

      // AHB then tlr_reset back to IDCODE
      commit(AHB, 1'b0);
      tlr_reset = 1'b1;
      push("tlr_po", 32'(IDCODE)); push("tlr_pulse", 32'd0);
      step(); pop(32'(parallel_out)); pop(32'(update_pulse));
      tlr_reset = 1'b0;

      // Capture and update together: update wins, chain (still AHB) not recaptured
      capture_ir = 1'b1;
      update_ir  = 1'b1;
      push("cu_po", 32'(AHB)); push("cu_pulse", 32'd1); push("cu_tdo", 32'd0);
      step(); pop(32'(parallel_out)); pop(32'(update_pulse)); pop(32'(ir_tdo));
      capture_ir = 1'b0;
      update_ir  = 1'b0;
      cur_po     = AHB;

      // TRST mid-shift discards the partial shift
      shift_ir = 1'b1;
      tdi      = 1'b1;
      step();
      step();
      TRST = 1'b1;
      push("trst_mid_po", 32'(IDCODE)); push("trst_mid_tdo", 32'd0);
      step(); pop(32'(parallel_out)); pop(32'(ir_tdo));
      TRST     = 1'b0;
      shift_ir = 1'b0;
      tdi      = 1'b0;
      cur_po   = IDCODE;

`ifdef IR_PARITY_EN
      // Parity: correct parity commits, flipped parity forces BYPASS and sticks
      commit(IDCODE, 1'b0);
      commit(IDCODE, 1'b1);
      push("perr_sticky", 32'd1);
      step(); pop(32'(parity_err));
      tlr_reset = 1'b1;
      push("perr_tlr_clr", 32'd0); push("perr_tlr_po", 32'(IDCODE));
      step(); pop(32'(parity_err)); pop(32'(parallel_out));
      tlr_reset = 1'b0;
`endif

      checks++;
      assert (sbq.size() == 0) else begin
         errors++;
         $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instruction_register.md
Name: instruction_register

Overview:
- JTAG instruction register (IR) stage that sits directly upstream of instruction_decoder and drives its parallel_out input.
- Captures the IEEE 1149.1 capture pattern plus status bits in Capture-IR, and shifts TDI→TDO in Shift-IR.
- Commits a legalised opcode to the update register on Update-IR. Illegal opcodes resolve to BYPASS.
- The TAP controller supplies the state strobes; the TDO mux consumes ir_tdo.

Parameters:
- IR_WIDTH, 4, instruction length in bits; must be at least 2 and must match the opcode width in jtag_types_pkg.
- STATUS_W, IR_WIDTH-2, number of status bits captured into shift bits [IR_WIDTH-1:2].

Ports:
- TCK  input  1  JTAG clock; all state updates on the rising edge.
- TRST  input  1  reset, synchronous, active-high.
- tlr_reset  input  1  TAP is in Test-Logic-Reset.
- capture_ir  input  1  TAP is in Capture-IR.
- shift_ir  input  1  TAP is in Shift-IR.
- update_ir  input  1  TAP is in Update-IR.
- tdi  input  1  serial data in.
- status  input  STATUS_W  status bits captured during Capture-IR.
- ir_tdo  output  1  serial data out, equal to shift_reg[0].
- parallel_out  output  IR_WIDTH  current instruction, fed to instruction_decoder.
- update_pulse  output  1  one-cycle pulse on the cycle after an update commits.
- parity_err  output  1  sticky parity failure flag (see Optional Feature).

Behaviour:
- One clock: TCK. Reset: TRST, synchronous, active-high.
- Internal state:
  - shift_reg[IR_WIDTH-1:0]
  - upd_reg[IR_WIDTH-1:0]: holds the committed opcode that drives parallel_out.
- Reset (TRST=1 at a rising edge):
  - shift_reg=0, upd_reg=IDCODE, update_pulse=0, parity_err=0.
  - ir_tdo therefore reads 0.
- Priority per cycle: TRST > tlr_reset > update_ir > capture_ir > shift_ir > hold.
- tlr_reset:
  - upd_reg=IDCODE, update_pulse=0, parity_err=0.
  - shift_reg holds its value.
- capture_ir: shift_reg <= {status, 2'b01}.
- shift_ir:
  - shift_reg <= {tdi, shift_reg[IR_WIDTH-1:1]}, i.e. LSB first out and TDI enters at the MSB.
  - ir_tdo is combinational from shift_reg[0] and is not retimed here; the falling-edge TDO retime lives downstream.
- update_ir:
  - Legal opcode set: BYPASS, SAMPLE, PRELOAD, EXTEST, IDCODE, AHB, CLAMP_HOLD, CLAMP_RELEASE from jtag_types_pkg.
  - If shift_reg is in the legal set, upd_reg <= shift_reg; otherwise upd_reg <= BYPASS.
  - update_pulse=1 in the next cycle only.
  - update_ir held for N cycles gives N pulses; each re-commits the same value.
- parallel_out:
  - Changes only on reset, tlr_reset or update_ir.
  - Stable through capture and shift, so the decoder outputs never glitch mid-scan.
- Simultaneous strobes (illegal from a correct TAP) resolve by the priority above; no error is flagged.
- TRST asserted mid-shift: the partial shift is discarded and the next cycle shows reset values.
- Legal-set check: combinational compare against the package constants. No hard-coded encodings in RTL.

Optional Feature:
- Macro: IR_PARITY_EN.
- When defined:
  - The shift chain is IR_WIDTH+1 bits. Bit IR_WIDTH is the parity bit and is the last bit shifted in.
  - capture_ir loads the parity bit with 0.
  - On update_ir, odd parity is required: XOR of all IR_WIDTH+1 bits must equal 1.
  - On failure: upd_reg <= BYPASS and parity_err <= 1.
  - On success: normal legalisation applies and parity_err <= 0.
  - parity_err is cleared by TRST or tlr_reset.
  - ir_tdo is still bit 0 of the chain.
- When undefined: chain is IR_WIDTH bits and parity_err is tied to 0.

Test Plan:
1. TRST=1 for 1 cycle → parallel_out=IDCODE, ir_tdo=0, update_pulse=0, parity_err=0.
2. IR_WIDTH=4, status=2'b10, capture_ir 1 cycle, then shift_ir 4 cycles with tdi=0 → ir_tdo sequence 1,0,0,1; shift_reg=4'b0000.
3. Shift EXTEST LSB-first, then update_ir → parallel_out=EXTEST one cycle later, update_pulse high exactly 1 cycle; parallel_out unchanged during the shift.
4. Shift an IR_WIDTH-bit value absent from the legal set, then update_ir → parallel_out=BYPASS.
5. After committing AHB, assert tlr_reset → parallel_out=IDCODE. Then assert capture_ir and update_ir in the same cycle → update wins and the decoded value is committed.
6. With IR_PARITY_EN: shift IDCODE with the correct odd-parity bit → parallel_out=IDCODE, parity_err=0. Flip the parity bit → parallel_out=BYPASS, parity_err=1 until tlr_reset.
